imem_loader: RTL and testbench

//   Writes a program image into the instruction memory, the write side of the port the CPU

---
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory image loader.
// Accepts a byte stream over valid/ready, packs big-endian 32-bit words, writes them to
// consecutive IM word addresses from 0, and validates the image with a trailing XOR
// checksum byte. The CPU is held off while a load is in progress or after a failed load.
module imem_loader #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DEPTH         = 1024,
  parameter bit          HOLD_AT_RESET = 1'b0
) (
  input  logic              clkN,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W:0]   load_words_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W:0]   DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IdxOne = ADDR_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  // Index of the final word (load_words - 1); only meaningful when load_words >= 1.
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [7:0]          acc_q, acc_d;
  logic [31:0]         word_q, word_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                hold_q, hold_d;

  logic                xfer;

  // Ready depends on state only, so the handshake never forms a combinational loop.
  assign byte_ready_o = (state_q == StRecv) || (state_q == StCheck);
  assign xfer         = byte_valid_i && byte_ready_o;

  assign im_we_o      = (state_q == StWrite);
  assign im_addr_o    = index_q;
  assign im_wdata_o   = word_q;
  assign cpu_hold_o   = hold_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign err_o        = err_q;

  // Next-state logic for the load sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    word_d  = word_q;
    done_d  = 1'b0;
    err_d   = err_q;
    hold_d  = hold_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d   = 1'b0;
          acc_d   = 8'h00;
          index_d = '0;
          cnt_d   = 2'd0;
          hold_d  = 1'b1;
          if (load_words_i > DepthW) begin
            // Oversized image: flag and stay idle with the CPU still held.
            err_d = 1'b1;
          end else if (load_words_i == '0) begin
            state_d = StCheck;
          end else begin
            last_d  = load_words_i[ADDR_W-1:0] - IdxOne;
            state_d = StRecv;
          end
        end
      end

      StRecv: begin
        if (xfer) begin
          // First byte of a word ends up in bits 31:24.
          word_d = {word_q[23:0], byte_data_i};
          acc_d  = acc_q ^ byte_data_i;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        if (index_q == last_q) begin
          state_d = StCheck;
        end else begin
          index_d = index_q + IdxOne;
          state_d = StRecv;
        end
      end

      StCheck: begin
        if (xfer) begin
          if (byte_data_i == acc_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clkN or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      last_q  <= '0;
      cnt_q   <= 2'd0;
      acc_q   <= 8'h00;
      word_q  <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= HOLD_AT_RESET;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected IM writes are queued as stimulus is
// driven and popped when the DUT pulses im_we.
module tb_imem_loader;

  localparam int unsigned AddrW = 10;

  logic             clkN = 1'b0;
  logic             rst;
  logic             start;
  logic [AddrW:0]   load_words;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             im_we;
  logic [AddrW-1:0] im_addr;
  logic [31:0]      im_wdata;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          we_cnt   = 0;
  logic [7:0]  acc_tb;
  logic [41:0] exp_q[$];
  logic [41:0] exp_e;

  imem_loader #(
    .ADDR_W       (AddrW),
    .DEPTH        (1024),
    .HOLD_AT_RESET(1'b0)
  ) dut (
    .clkN        (clkN),
    .rst         (rst),
    .start_i     (start),
    .load_words_i(load_words),
    .byte_valid_i(byte_valid),
    .byte_data_i (byte_data),
    .byte_ready_o(byte_ready),
    .im_we_o     (im_we),
    .im_addr_o   (im_addr),
    .im_wdata_o  (im_wdata),
    .cpu_hold_o  (cpu_hold),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clkN = ~clkN;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every IM write against the queued expectation.
  always @(negedge clkN) begin
    if (!rst) begin
      if (im_we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          check_val("spurious_we", 32'(im_we), 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check_val("im_addr", 32'(im_addr), 32'(exp_e[41:32]));
          check_val("im_wdata", im_wdata, exp_e[31:0]);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_q.push_back({10'(addr), data});
  endtask

  // Offer one byte after 'gap' idle cycles; returns one step after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clkN);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    @(negedge clkN);
    while (!byte_ready && k < 40) begin
      @(negedge clkN);
      k++;
    end
    if (!byte_ready) begin
      check_val("ready_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clkN);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 3; i >= 0; i--) begin
      acc_tb = acc_tb ^ w[i*8 +: 8];
      send_byte(w[i*8 +: 8], rnd ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic start_load(input int n);
    start      = 1'b1;
    load_words = 11'(n);
    @(posedge clkN);
    #1;
    start  = 1'b0;
    acc_tb = 8'h00;
  endtask

  task automatic settle();
    repeat (3) @(posedge clkN);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int w0;
    rst        = 1'b1;
    start      = 1'b0;
    load_words = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clkN);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ready", 32'(byte_ready), 32'd0);
    check_val("rst_hold", 32'(cpu_hold), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_addr", 32'(im_addr), 32'd0);
    rst = 1'b0;
    @(posedge clkN);
    #1;

    // 1) Good two-word load.
    d0 = done_cnt;
    push_exp(0, 32'h2008_0005);
    push_exp(1, 32'h0000_0000);
    start_load(2);
    check_val("t1_hold_on", 32'(cpu_hold), 32'd1);
    check_val("t1_busy", 32'(busy), 32'd1);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    check_val("t1_acc", 32'(acc_tb), 32'h2D);
    send_byte(8'h2D, 0);
    settle();
    check_val("t1_done", 32'(done_cnt - d0), 32'd1);
    check_val("t1_err", 32'(err), 32'd0);
    check_val("t1_hold_off", 32'(cpu_hold), 32'd0);
    check_val("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2) Same image, wrong checksum.
    d0 = done_cnt;
    push_exp(0, 32'h2008_0005);
    push_exp(1, 32'h0000_0000);
    start_load(2);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    send_byte(8'h2C, 0);
    settle();
    check_val("t2_done", 32'(done_cnt - d0), 32'd0);
    check_val("t2_err", 32'(err), 32'd1);
    check_val("t2_hold", 32'(cpu_hold), 32'd1);
    check_val("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3) Random valid gaps; zero-gap bytes land on the WRITE cycle and must be held.
    d0 = done_cnt;
    push_exp(0, 32'h2008_0005);
    push_exp(1, 32'h0000_0000);
    start_load(2);
    check_val("t3_err_clr", 32'(err), 32'd0);
    send_word(32'h2008_0005, 1'b1);
    send_word(32'h0000_0000, 1'b1);
    send_byte(acc_tb, 1);
    settle();
    check_val("t3_done", 32'(done_cnt - d0), 32'd1);
    check_val("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4) Reset after five accepted bytes, then a fresh one-word load.
    push_exp(0, 32'hCAFE_F00D);
    start_load(2);
    send_word(32'hCAFE_F00D, 1'b0);
    send_byte(8'h99, 0);
    rst = 1'b1;
    #1;
    check_val("t4_busy", 32'(busy), 32'd0);
    check_val("t4_ready", 32'(byte_ready), 32'd0);
    check_val("t4_we", 32'(im_we), 32'd0);
    check_val("t4_addr", 32'(im_addr), 32'd0);
    check_val("t4_wdata", im_wdata, 32'd0);
    check_val("t4_hold", 32'(cpu_hold), 32'd0);
    check_val("t4_err", 32'(err), 32'd0);
    check_val("t4_done", 32'(done), 32'd0);
    @(posedge clkN);
    #1;
    rst = 1'b0;
    @(posedge clkN);
    #1;
    d0 = done_cnt;
    push_exp(0, 32'h1122_3344);
    start_load(1);
    send_word(32'h1122_3344, 1'b0);
    check_val("t4_acc", 32'(acc_tb), 32'h44);
    send_byte(8'h44, 0);
    settle();
    check_val("t4_done_new", 32'(done_cnt - d0), 32'd1);
    check_val("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5) Oversized image, then an empty image.
    w0 = we_cnt;
    start_load(1025);
    settle();
    check_val("t5_err", 32'(err), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_hold", 32'(cpu_hold), 32'd1);
    check_val("t5_no_we", 32'(we_cnt - w0), 32'd0);
    d0 = done_cnt;
    start_load(0);
    check_val("t5_zero_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 0);
    settle();
    check_val("t5_zero_done", 32'(done_cnt - d0), 32'd1);
    check_val("t5_zero_no_we", 32'(we_cnt - w0), 32'd0);
    check_val("t5_zero_err", 32'(err), 32'd0);
    check_val("t5_zero_hold", 32'(cpu_hold), 32'd0);

    // 6) start pulses during a load are ignored.
    d0 = done_cnt;
    push_exp(0, 32'hA5A5_0001);
    push_exp(1, 32'h0BAD_BEEF);
    push_exp(2, 32'h7F00_FF80);
    start_load(3);
    acc_tb = acc_tb ^ 8'hA5;
    send_byte(8'hA5, 0);
    start      = 1'b1;
    load_words = 11'd1;
    @(posedge clkN);
    #1;
    start  = 1'b0;
    acc_tb = acc_tb ^ 8'hA5 ^ 8'h00 ^ 8'h01;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h0BAD_BEEF, 1'b1);
    start = 1'b1;
    @(posedge clkN);
    #1;
    start = 1'b0;
    send_word(32'h7F00_FF80, 1'b0);
    send_byte(acc_tb, 0);
    settle();
    check_val("t6_done", 32'(done_cnt - d0), 32'd1);
    check_val("t6_err", 32'(err), 32'd0);
    check_val("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
